// File: rtl/jt12_ch_wr_if.sv
// rtl/jt12_ch_wr_if.sv - CPU-side write bus for the channel register front end
interface jt12_ch_wr_if;
    logic       write;
    logic [1:0] addr;
    logic [7:0] din;
    logic       busy;

    modport master (output write, addr, din, input busy);
    modport slave  (input write, addr, din, output busy);
endinterface

// File: rtl/jt12_ch_wr.sv
// rtl/jt12_ch_wr.sv - channel register write decoder (A0h-B6h) with write-busy counter
// Address writes latch the register/part; data writes raise one-cycle update strobes.
module jt12_ch_wr #(
    parameter int NUM_CH      = 6,
    parameter int BUSY_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    jt12_ch_wr_if.slave       bus,
    output logic [2:0]        up_ch,
    output logic [5:0]        latch_fnum,
    output logic              up_fnumlo,
    output logic              up_alg,
    output logic              up_pms,
    output logic [7:0]        dout
);
    localparam logic [5:0] BUSY_LOAD = 6'(BUSY_CYCLES);
    localparam logic       PART_EN   = (NUM_CH != 3);

    logic [7:0] sel_reg;
    logic       sel_part;
    logic [5:0] busy_cnt;

    logic       addr_wr;
    logic       data_wr;
    logic [1:0] ch_idx;
    logic       ch_valid;
    logic [2:0] tgt_ch;
    logic       hit_fnumlo;
    logic       hit_latch;
    logic       hit_alg;
    logic       hit_pms;

    // Registers are grouped in fours: bits [7:2] pick the group, [1:0] the channel.
    always_comb begin
        addr_wr    = bus.write & ~bus.addr[0];
        data_wr    = bus.write &  bus.addr[0];
        ch_idx     = sel_reg[1:0];
        ch_valid   = (ch_idx != 2'd3);
        tgt_ch     = sel_part ? ({1'b0, ch_idx} + 3'd3) : {1'b0, ch_idx};
        hit_fnumlo = data_wr & ch_valid & (sel_reg[7:2] == 6'b101000);
        hit_latch  = data_wr & ch_valid & (sel_reg[7:2] == 6'b101001);
        hit_alg    = data_wr & ch_valid & (sel_reg[7:2] == 6'b101100);
        hit_pms    = data_wr & ch_valid & (sel_reg[7:2] == 6'b101101);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_reg    <= 8'd0;
            sel_part   <= 1'b0;
            up_ch      <= 3'd0;
            latch_fnum <= 6'd0;
            up_fnumlo  <= 1'b0;
            up_alg     <= 1'b0;
            up_pms     <= 1'b0;
            dout       <= 8'd0;
        end else begin
            up_fnumlo <= hit_fnumlo;
            up_alg    <= hit_alg;
            up_pms    <= hit_pms;
            if (addr_wr) begin
                sel_reg  <= bus.din;
                sel_part <= bus.addr[1] & PART_EN;
            end
            if (hit_latch) begin
                latch_fnum <= bus.din[5:0];
            end
            // Channel and data only move with a strobe so they hold between updates.
            if (hit_fnumlo | hit_alg | hit_pms) begin
                up_ch <= tgt_ch;
                dout  <= bus.din;
            end
        end
    end

    // A load takes priority over a coincident cen so the full count is always seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt <= 6'd0;
        end else if (data_wr) begin
            busy_cnt <= BUSY_LOAD;
        end else if (cen && busy_cnt != 6'd0) begin
            busy_cnt <= busy_cnt - 6'd1;
        end
    end

    assign bus.busy = (busy_cnt != 6'd0);
endmodule
